// File: rtl/axi_dma_pkg.sv
// Shared types and helpers for the DMA AXI command path.
// Used by the read-command generator and its burst calculator.
package axi_dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         PAGE_BYTES     = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ADDR  = 2'd2,
        DRAIN = 2'd3
    } rd_cmd_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] size_from_bytes(input int bytes);
        return 3'(clog2(bytes));
    endfunction

endpackage

// File: rtl/rd_burst_calc.sv
// Combinational burst-length limiter: min of remaining beats,
// MAX_BURST and the beats left before the next 4 KB page.
module rd_burst_calc
    import axi_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 20,
    parameter int MAX_BURST  = 256
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [LEN_WIDTH-1:0]  blen
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = clog2(BYTES);
    localparam int CW    = (LEN_WIDTH > 14) ? LEN_WIDTH : 14;

    logic [12:0]   page_bytes;
    logic [12:0]   page_beats;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] page_w;
    logic [CW-1:0] min_a;
    logic [CW-1:0] min_b;

    // Min-of-three in a common width wide enough for every operand.
    always_comb begin
        page_bytes = 13'(PAGE_BYTES) - {1'b0, addr[11:0]};
        page_beats = page_bytes >> SHIFT;
        rem_w      = CW'(remaining);
        max_w      = CW'(MAX_BURST);
        page_w     = CW'(page_beats);
        min_a      = (rem_w < max_w) ? rem_w : max_w;
        min_b      = (min_a < page_w) ? min_a : page_w;
        blen       = LEN_WIDTH'(min_b);
    end

endmodule

// File: rtl/axi_rd_cmd_gen.sv
// AXI4 read-address command generator: splits a DMA read into
// page-safe INCR bursts and throttles them by outstanding count.
module axi_rd_cmd_gen
    import axi_dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 20,
    parameter int MAX_BURST       = 256,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [LEN_WIDTH-1:0]  num_beats,
    output logic                  busy,
    output logic                  done,
    input  logic                  burst_done,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = clog2(BYTES);
    localparam int OW    = clog2(MAX_OUTSTANDING + 1);

    localparam logic [OW-1:0]         OUT_MAX    = OW'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);

    if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("axi_rd_cmd_gen: MAX_BURST must be 1..256");
    end

    if (BYTES < 1 || BYTES > 128 || (BYTES & (BYTES - 1)) != 0) begin : g_bad_bytes
        $error("axi_rd_cmd_gen: DATA_WIDTH/8 must be a power of two, 1..128");
    end

    rd_cmd_state_t         state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [LEN_WIDTH-1:0]  blen_q;
    logic [LEN_WIDTH-1:0]  blen;
    logic [OW-1:0]         outstanding_q;
    logic                  ar_hs;
    logic                  bd_take;

    assign M_AXI_ARSIZE  = size_from_bytes(BYTES);
    assign M_AXI_ARBURST = AXI_BURST_INCR;

    assign ar_hs   = M_AXI_ARVALID & M_AXI_ARREADY;
    assign bd_take = burst_done & (outstanding_q != '0);

    rd_burst_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_calc (
        .addr      (addr_q),
        .remaining (remaining_q),
        .blen      (blen)
    );

    // Track accepted-but-uncompleted bursts; completions at zero are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
        end else if (ar_hs && !bd_take) begin
            outstanding_q <= outstanding_q + OW'(1);
        end else if (!ar_hs && bd_take) begin
            outstanding_q <= outstanding_q - OW'(1);
        end
    end

    // Command FSM: latch request, size each burst, hold AR until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            blen_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
            M_AXI_ARVALID <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_beats == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr_q      <= src_addr & ~ALIGN_MASK;
                            remaining_q <= num_beats;
                            busy        <= 1'b1;
                            state_q     <= CALC;
                        end
                    end
                end
                CALC: begin
                    M_AXI_ARADDR <= addr_q;
                    M_AXI_ARLEN  <= 8'(blen - LEN_ONE);
                    blen_q       <= blen;
                    if (outstanding_q < OUT_MAX) begin
                        M_AXI_ARVALID <= 1'b1;
                        state_q       <= ADDR;
                    end
                end
                ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        addr_q        <= addr_q + (ADDR_WIDTH'(blen_q) << SHIFT);
                        remaining_q   <= remaining_q - blen_q;
                        if (remaining_q == blen_q) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding_q == '0) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_cmd_gen.sv
// Directed bench for axi_rd_cmd_gen: table of transfers plus
// hand-written throttle, backpressure, zero-length and reset cases.
module tb_axi_rd_cmd_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [19:0] num_beats;
    logic        busy;
    logic        done;
    logic        burst_done;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    int errors;
    int checks;

    axi_rd_cmd_gen #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .LEN_WIDTH       (20),
        .MAX_BURST       (256),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_addr      (src_addr),
        .num_beats     (num_beats),
        .busy          (busy),
        .done          (done),
        .burst_done    (burst_done),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] hs_addr[$];
    logic [7:0]  hs_len[$];
    int          hs_count = 0;
    int          bd_count = 0;
    int          bd_req = 0;
    int          bd_served = 0;
    bit          auto_bd = 1'b1;

    always @(posedge clk) begin
        if (!rst && arvalid && arready) begin
            hs_addr.push_back(araddr);
            hs_len.push_back(arlen);
            hs_count = hs_count + 1;
        end
    end

    initial begin
        burst_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bd_count   = hs_count;
                burst_done = 1'b0;
            end else if ((auto_bd && hs_count > bd_count) || bd_req > bd_served) begin
                burst_done = 1'b1;
                bd_count   = bd_count + 1;
                if (bd_req > bd_served) bd_served = bd_served + 1;
            end else begin
                burst_done = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        bit found;
        int extra;
        found = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(found), 64'd1);
        if (found) begin
            check({name, "_busy_at_done"}, 64'(busy), 64'd0);
            extra = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check({name, "_single_done"}, 64'(extra), 64'd0);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [19:0] beats;
        int          n;
        logic [31:0] ea[4];
        logic [7:0]  el[4];
    } vec_t;

    vec_t vecs[6];

    task automatic apply_vec(input int k);
        int base;
        base = hs_count;
        @(negedge clk);
        start     = 1'b1;
        src_addr  = vecs[k].addr;
        num_beats = vecs[k].beats;
        @(negedge clk);
        src_addr  = 32'h0000_5000;
        num_beats = 20'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done($sformatf("vec%0d", k), 3000);
        check($sformatf("vec%0d_nbursts", k), 64'(hs_count - base), 64'(vecs[k].n));
        for (int i = 0; i < vecs[k].n; i++) begin
            if (base + i < hs_count) begin
                check($sformatf("vec%0d_araddr%0d", k, i), 64'(hs_addr[base + i]), 64'(vecs[k].ea[i]));
                check($sformatf("vec%0d_arlen%0d", k, i), 64'(hs_len[base + i]), 64'(vecs[k].el[i]));
            end
        end
    endtask

    initial begin
        int  base;
        bit  found;
        bit  saw_valid;
        bit  saw_busy;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        num_beats = '0;
        arready   = 1'b1;

        vecs[0].addr = 32'h0000_1000; vecs[0].beats = 20'd600; vecs[0].n = 3;
        vecs[0].ea[0] = 32'h1000; vecs[0].ea[1] = 32'h1400; vecs[0].ea[2] = 32'h1800;
        vecs[0].el[0] = 8'd255;   vecs[0].el[1] = 8'd255;   vecs[0].el[2] = 8'd87;
        vecs[1].addr = 32'h0000_0FF0; vecs[1].beats = 20'd16; vecs[1].n = 2;
        vecs[1].ea[0] = 32'h0FF0; vecs[1].ea[1] = 32'h1000;
        vecs[1].el[0] = 8'd3;     vecs[1].el[1] = 8'd11;
        vecs[2].addr = 32'h0000_0FFC; vecs[2].beats = 20'd2; vecs[2].n = 2;
        vecs[2].ea[0] = 32'h0FFC; vecs[2].ea[1] = 32'h1000;
        vecs[2].el[0] = 8'd0;     vecs[2].el[1] = 8'd0;
        vecs[3].addr = 32'h0000_2003; vecs[3].beats = 20'd3; vecs[3].n = 1;
        vecs[3].ea[0] = 32'h2000; vecs[3].el[0] = 8'd2;
        vecs[4].addr = 32'hFFFF_FFF8; vecs[4].beats = 20'd4; vecs[4].n = 2;
        vecs[4].ea[0] = 32'hFFFF_FFF8; vecs[4].ea[1] = 32'h0;
        vecs[4].el[0] = 8'd1;          vecs[4].el[1] = 8'd1;
        vecs[5].addr = 32'h0000_0000; vecs[5].beats = 20'd257; vecs[5].n = 2;
        vecs[5].ea[0] = 32'h0; vecs[5].ea[1] = 32'h400;
        vecs[5].el[0] = 8'd255; vecs[5].el[1] = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("rst_arlen", 64'(arlen), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("arsize", 64'(arsize), 64'd2);
        check("arburst", 64'(arburst), 64'd1);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            apply_vec(k);
        end

        // Outstanding limit of 2 with completions withheld.
        auto_bd = 1'b0;
        base = hs_count;
        @(negedge clk);
        start     = 1'b1;
        src_addr  = 32'h0;
        num_beats = 20'd1024;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("thr_two_hs", 64'(hs_count - base), 64'd2);
        check("thr_stall_arvalid", 64'(arvalid), 64'd0);
        check("thr_busy", 64'(busy), 64'd1);
        bd_req = bd_req + 1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (hs_count - base == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("thr_third_hs", 64'(found), 64'd1);
        if (found) begin
            check("thr_third_addr", 64'(hs_addr[base + 2]), 64'h800);
            check("thr_third_len", 64'(hs_len[base + 2]), 64'd255);
        end
        auto_bd = 1'b1;
        wait_done("thr", 3000);
        check("thr_total_hs", 64'(hs_count - base), 64'd4);

        // ARREADY held low while a burst is presented.
        arready = 1'b0;
        base = hs_count;
        @(negedge clk);
        start     = 1'b1;
        src_addr  = 32'h0000_3000;
        num_beats = 20'd8;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (arvalid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_arvalid_seen", 64'(found), 64'd1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_hold%0d", c), {31'd0, arvalid, araddr}, {31'd0, 1'b1, 32'h3000});
            check($sformatf("bp_len%0d", c), 64'(arlen), 64'd7);
            if (c < 4) @(negedge clk);
        end
        arready = 1'b1;
        wait_done("bp", 200);
        check("bp_one_hs", 64'(hs_count - base), 64'd1);

        // Zero-length request.
        base = hs_count;
        @(negedge clk);
        start     = 1'b1;
        src_addr  = 32'h0000_4000;
        num_beats = 20'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("zero_done_width", 64'(done), 64'd0);
        saw_valid = 1'b0;
        saw_busy  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (arvalid) saw_valid = 1'b1;
            if (busy) saw_busy = 1'b1;
            @(negedge clk);
        end
        check("zero_no_arvalid", 64'(saw_valid), 64'd0);
        check("zero_no_busy", 64'(saw_busy), 64'd0);
        check("zero_no_hs", 64'(hs_count - base), 64'd0);

        // Reset while a second burst waits in ADDR with one outstanding.
        auto_bd = 1'b0;
        base = hs_count;
        @(negedge clk);
        start     = 1'b1;
        src_addr  = 32'h0000_1000;
        num_beats = 20'd600;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (hs_count - base == 1) begin
                found = 1'b1;
                break;
            end
        end
        arready = 1'b0;
        check("rst6_first_hs", 64'(found), 64'd1);
        repeat (2) @(negedge clk);
        check("rst6_arvalid_before", 64'(arvalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst6_arvalid", 64'(arvalid), 64'd0);
        check("rst6_busy", 64'(busy), 64'd0);
        check("rst6_outstanding", 64'(dut.outstanding_q), 64'd0);
        check("rst6_done", 64'(done), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        arready = 1'b1;
        auto_bd = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || arvalid) saw_valid = 1'b1;
        end
        check("rst6_quiet_after", 64'(saw_valid), 64'd0);
        apply_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
